// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle signed integer divider. Radix-2 non-restoring
//             iteration, one quotient bit per clock. Quotient truncates
//             toward zero; remainder takes the sign of the dividend.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_ITER  = 2'd2,
      S_FIX   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             neg_a_q, neg_a_d, neg_q_q, neg_q_d;
   logic [WIDTH:0]   abs_b_q, abs_b_d;
   logic [WIDTH+1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
   logic             exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
   logic             rst_sync_q;

   // Datapath helpers: magnitudes, one non-restoring step, final correction
   logic [WIDTH-1:0] abs_a, abs_b, rem_fix, quo_out, rem_out;
   logic [WIDTH+1:0] shift_rem, next_rem;

   assign abs_a     = a_q[WIDTH-1] ? (~a_q) + WIDTH'(1) : a_q;
   assign abs_b     = b_q[WIDTH-1] ? (~b_q) + WIDTH'(1) : b_q;
   assign shift_rem = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
   assign next_rem  = rem_q[WIDTH+1] ? shift_rem + {1'b0, abs_b_q}
                                     : shift_rem - {1'b0, abs_b_q};
   // Corrected remainder magnitude is below |B| <= 2^(WIDTH-1), so the low
   // WIDTH bits of the modular sum are exact.
   assign rem_fix   = rem_q[WIDTH+1] ? rem_q[WIDTH-1:0] + abs_b_q[WIDTH-1:0]
                                     : rem_q[WIDTH-1:0];
   assign quo_out   = neg_q_q ? (~quo_q) + WIDTH'(1) : quo_q;
   assign rem_out   = neg_a_q ? (~rem_fix) + WIDTH'(1) : rem_fix;

   // Reset release is synchronised so the first edge after release is idle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 1'b0;
      else          rst_sync_q <= 1'b1;
   end

   // Next-state and datapath computation; a start pulse always wins
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      neg_a_d     = neg_a_q;
      neg_q_d     = neg_q_q;
      abs_b_d     = abs_b_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      exc_d       = exc_q;
      rdy_d       = 1'b0;
      busy_d      = busy_q;
      if (ctrl_DIV) begin
         // Start, or abort the operation in flight and restart
         a_d     = data_operandA;
         b_d     = data_operandB;
         neg_a_d = data_operandA[WIDTH-1];
         neg_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         state_d = S_SETUP;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            S_SETUP: begin
               quo_d   = abs_a;
               abs_b_d = {1'b0, abs_b};
               rem_d   = '0;
               cnt_d   = '0;
               state_d = S_ITER;
            end
            S_ITER: begin
               rem_d = next_rem;
               quo_d = {quo_q[WIDTH-2:0], ~next_rem[WIDTH+1]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) state_d = S_FIX;
            end
            S_FIX: begin
               if (b_q == '0) begin
                  result_d    = '0;
                  remainder_d = a_q;
                  exc_d       = 1'b1;
               end else begin
                  // MIN / -1 naturally yields MIN and 0; only the flag differs
                  result_d    = quo_out;
                  remainder_d = rem_out;
                  exc_d       = (a_q == MIN_VAL) && (b_q == '1);
               end
               rdy_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n || !rst_sync_q) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         neg_a_q     <= 1'b0;
         neg_q_q     <= 1'b0;
         abs_b_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         remainder_q <= '0;
         exc_q       <= 1'b0;
         rdy_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         neg_a_q     <= neg_a_d;
         neg_q_q     <= neg_q_d;
         abs_b_q     <= abs_b_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         exc_q       <= exc_d;
         rdy_q       <= rdy_d;
         busy_q      <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_remainder = remainder_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider against an arithmetic
//             reference model (directed corner cases plus random operands).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

   localparam int WIDTH   = 32;
   localparam int LATENCY = WIDTH + 2;

   logic             clock;
   logic             reset_n;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA, data_operandB;
   logic [WIDTH-1:0] data_result, data_remainder;
   logic             data_exception, data_resultRDY, busy;

   int n_checks = 0;
   int n_pass   = 0;

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: plain signed division with the two exception rules
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic e);
      int sa, sb;
      sa = a;
      sb = b;
      if (sb == 0) begin
         q = 32'd0; r = a; e = 1'b1;
      end else if (a == 32'h8000_0000 && sb == -1) begin
         q = 32'h8000_0000; r = 32'd0; e = 1'b1;
      end else begin
         q = sa / sb; r = sa % sb; e = 1'b0;
      end
   endtask

   // Drive a start pulse; returns just after the sampling edge E0
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // From E0, follow busy/ready up to the result and compare with the model
   task automatic wait_result(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic        ee;
      int          k;
      bit          seen, busy_bad, early;
      model(a, b, eq, er, ee);
      seen = 0; busy_bad = 0; early = 0;
      for (k = 1; k <= LATENCY + 10; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            seen = 1;
            break;
         end
         if (!busy) busy_bad = 1;
      end
      chk({tag, "_ready_seen"}, seen, 1'b1);
      if (seen) begin
         chk({tag, "_latency"}, k, LATENCY);
         chk({tag, "_busy_during"}, busy_bad, 1'b0);
         chk({tag, "_busy_at_rdy"}, busy, 1'b0);
         chk({tag, "_quotient"}, data_result, eq);
         chk({tag, "_remainder"}, data_remainder, er);
         chk({tag, "_exception"}, data_exception, ee);
      end
      if (early) chk({tag, "_early"}, early, 1'b0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_result"}, data_result, 0);
      chk({tag, "_remainder"}, data_remainder, 0);
      chk({tag, "_exception"}, data_exception, 0);
      chk({tag, "_rdy"}, data_resultRDY, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          stray;
      reset_n       = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check_outputs_zero("reset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(posedge clock);

      // Basic case plus ready pulse width
      start_op(32'd100, 32'd7);
      wait_result("basic", 32'd100, 32'd7);
      @(posedge clock);
      #1;
      chk("rdy_one_cycle", data_resultRDY, 1'b0);
      chk("hold_quotient", data_result, 32'd14);

      // Signs and corner cases
      start_op(-32'sd100, 32'd7);          wait_result("neg_a", -32'sd100, 32'd7);
      start_op(32'd100, -32'sd7);          wait_result("neg_b", 32'd100, -32'sd7);
      start_op(-32'sd100, -32'sd7);        wait_result("neg_ab", -32'sd100, -32'sd7);
      start_op(32'h8000_0000, 32'hFFFF_FFFF); wait_result("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
      start_op(32'h8000_0000, 32'd1);      wait_result("min_by_1", 32'h8000_0000, 32'd1);
      start_op(32'd55, 32'd0);             wait_result("div0", 32'd55, 32'd0);
      start_op(32'd7, 32'h8000_0000);      wait_result("by_min", 32'd7, 32'h8000_0000);

      // Start issued in the ready cycle is honoured
      start_op(32'd1000, 32'd33);
      wait_result("b2b_first", 32'd1000, 32'd33);
      start_op(32'd12345, -32'sd10);
      wait_result("b2b_second", 32'd12345, -32'sd10);

      // Abort: restart at E10, no ready for the first operation
      start_op(32'd100, 32'd7);
      stray = 0;
      repeat (9) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) stray = 1;
      end
      start_op(32'd9, 32'd3);
      chk("abort_no_early_rdy", stray, 1'b0);
      wait_result("abort", 32'd9, 32'd3);

      // Random operands
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(0, 40)) - 32'd20;
            2: rb = 32'($urandom_range(1, 255));
            3: begin ra = 32'h8000_0000; rb = 32'($urandom_range(0, 2)) - 32'd1; end
            default: rb = {16'h0, 16'($urandom)};
         endcase
         start_op(ra, rb);
         wait_result("rand", ra, rb);
      end

      // Reset mid-operation
      start_op(32'd100, 32'd7);
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      stray = 0;
      repeat (LATENCY + 6) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) stray = 1;
      end
      chk("midreset_no_rdy", stray, 1'b0);
      start_op(32'd21, 32'd4);
      wait_result("after_reset", 32'd21, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Multi-cycle signed integer divider for the processor's multdiv path; it complements the adder/multiplier datapath by implementing division. It accepts a one-cycle start pulse with two operands and runs a radix-2 non-restoring iteration, one quotient bit per clock. After a fixed latency it presents a quotient, a remainder and an exception flag, with a one-cycle ready pulse. The execute stage stalls on `busy` and captures the result on `data_resultRDY`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width (two's complement).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_DIV`  in  1  start pulse; operands are sampled on the edge where it is high.
- `data_operandA`  in  WIDTH  dividend.
- `data_operandB`  in  WIDTH  divisor.
- `data_result`  out  WIDTH  quotient, truncated toward zero.
- `data_remainder`  out  WIDTH  remainder; its sign follows the dividend.
- `data_exception`  out  1  high for divide-by-zero or for MIN / -1.
- `data_resultRDY`  out  1  one-cycle pulse: results are valid.
- `busy`  out  1  high while an operation is in flight.

## Operation
- States: IDLE, SETUP, ITER, FIX.
- IDLE, with `ctrl_DIV`=1:
  - latch A and B, the sign of A, and the sign of A XOR B;
  - go to SETUP; `busy`=1.
- SETUP:
  - form |A| and |B| in WIDTH+1-bit unsigned form, so that MIN is representable;
  - clear the partial remainder and the count;
  - go to ITER.
- ITER, repeated WIDTH times:
  - shift {remainder, quotient} left by one;
  - if the remainder is non-negative, subtract |B|, otherwise add |B|;
  - the new quotient LSB is the inverse of the remainder sign;
  - the 5-bit count (sized clog2(WIDTH)) is incremented;
  - after the WIDTH-th iteration, go to FIX.
- FIX:
  - if the remainder is negative, add |B| once;
  - negate the quotient if the A XOR B sign is 1; negate the remainder if A is negative;
  - load the output registers; `data_resultRDY`=1; `busy`=0; go to IDLE.
- Divide-by-zero (B=0):
  - latency is identical to a normal operation;
  - outputs are `data_result`=0, `data_remainder`=A, `data_exception`=1.
- Overflow (A=MIN, B=-1): `data_result`=MIN, `data_remainder`=0, `data_exception`=1.
- All other cases: `data_exception`=0.
- `ctrl_DIV` while busy: the current operation is aborted. New operands are latched, the state goes to SETUP, and the latency restarts from that edge. No `data_resultRDY` is produced for the aborted operation.
- Output registers hold their last value until the next FIX completes. Operand changes while busy have no effect.
- Reset (`reset_n`=0, at any time including mid-operation):
  - state returns to IDLE at once;
  - all outputs are 0: `data_result`, `data_remainder`, `data_exception`, `data_resultRDY`, `busy`;
  - the count and internal registers are cleared;
  - no ready pulse is produced after release.

## Timing
- E0 is the edge sampling `ctrl_DIV`=1. The state sequence is:
  - E0: enter SETUP, `busy` goes high;
  - E1: enter ITER;
  - E2..E(WIDTH+1): iterations;
  - E(WIDTH+1): enter FIX;
  - E(WIDTH+2): results registered.
- `data_resultRDY` is high for exactly the one cycle following edge E(WIDTH+2). That is E34 for WIDTH=32.
- `busy` is high from after E0 until after E(WIDTH+2), and low in the same cycle that `data_resultRDY` is high.
- `ctrl_DIV` in the ready cycle is a legal new start: the ready pulse is still produced and the new operation begins.
- `reset_n` deassertion is synchronised internally; the first legal `ctrl_DIV` is the second rising edge after release.
- No combinational path from inputs to outputs.

## Test plan
- A=100, B=7 -> at E34: result=14, remainder=2, exception=0. Ready is high for exactly 1 cycle; `busy` is high for 34 cycles.
- Sign cases:
  - A=-100, B=7 -> result=-14 (0xFFFFFFF2), remainder=-2.
  - A=100, B=-7 -> 14... corrected: result=-14, remainder=2.
  - A=-100, B=-7 -> result=14, remainder=-2.
- A=0x80000000, B=-1 -> result=0x80000000, remainder=0, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0.
- A=55, B=0 -> at E34: result=0, remainder=55, exception=1.
- Abort: start 100/7, then at E10 start 9/3 -> no ready at E34; ready at E10+34 with result=3, remainder=0.
- Reset mid-operation: start 100/7, pull `reset_n` low at E15 between edges -> all outputs 0 immediately and no ready pulse follows. Then, after release, the next start 21/4 -> result=5, remainder=1.
